// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU; one-cycle logic/arith/shift/compare, iterative MULU/MULHU and DIVU/REMU.
// Divider present only when ALU_MC_DIV_EN is defined; otherwise ops 12-13 report Illegal.
`default_nettype none
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Port_A,
  input  logic [WIDTH-1:0] Port_B,
  input  logic [3:0]       ALUOP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Output_Port,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
  output logic             Illegal
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d, o_q, o_d, il_q, il_d;

  logic             accept, is_mul, is_div;
  logic [WIDTH-1:0] add_w, sub_w, alu_res, ld_res;
  logic             alu_ovf, alu_ill, ld, ld_ovf, ld_ill;
  logic [WIDTH:0]   mul_sum;

  assign in_ready = !RST && (state_q == S_IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ALUOP[3:1] == 3'b101);
`ifdef ALU_MC_DIV_EN
  assign is_div   = (ALUOP[3:1] == 3'b110);
`else
  assign is_div   = 1'b0;
`endif

  assign add_w   = Port_A + Port_B;
  assign sub_w   = Port_A - Port_B;
  // Shift-add step: conditionally add multiplicand, then shift {carry,hi,lo} right.
  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};

`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  assign div_sh  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, b_q});
  assign div_sub = div_sh[WIDTH-1:0] - b_q;
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ALUOP)
      4'd0: alu_res = Port_A << Port_B[SW-1:0];
      4'd1: alu_res = Port_A >> Port_B[SW-1:0];
      4'd2: begin
        alu_res = add_w;
        alu_ovf = (Port_A[WIDTH-1] == Port_B[WIDTH-1]) && (add_w[WIDTH-1] != Port_A[WIDTH-1]);
      end
      4'd3: begin
        alu_res = sub_w;
        alu_ovf = (Port_A[WIDTH-1] != Port_B[WIDTH-1]) && (sub_w[WIDTH-1] != Port_A[WIDTH-1]);
      end
      4'd4: alu_res = Port_A & Port_B;
      4'd5: alu_res = Port_A | Port_B;
      4'd6: alu_res = Port_A ^ Port_B;
      4'd7: alu_res = ~(Port_A | Port_B);
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, ($signed(Port_A) < $signed(Port_B))};
      4'd9: alu_res = {{(WIDTH-1){1'b0}}, (Port_A < Port_B)};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    o_d     = o_q;
    il_d    = il_q;
    ld      = 1'b0;
    ld_res  = '0;
    ld_ovf  = 1'b0;
    ld_ill  = 1'b0;
    if (vld_q && out_ready) vld_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul || is_div) begin
            // Both iterate on {hi,lo} with lo preloaded from A; sel picks high half / remainder.
            state_d = is_div ? S_DIV : S_MUL;
            cnt_d   = CW'(WIDTH);
            b_d     = Port_B;
            hi_d    = '0;
            lo_d    = Port_A;
            sel_d   = ALUOP[0];
          end else begin
            ld     = 1'b1;
            ld_res = alu_res;
            ld_ovf = alu_ovf;
            ld_ill = alu_ill;
          end
        end
      end
      S_MUL: begin
        if (cnt_q != '0) begin
          hi_d  = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q - CW'(1);
        end else begin
          ld      = 1'b1;
          ld_res  = sel_q ? hi_q : lo_q;
          ld_ovf  = !sel_q && (hi_q != '0);
          state_d = S_IDLE;
        end
      end
`ifdef ALU_MC_DIV_EN
      S_DIV: begin
        if (cnt_q != '0) begin
          hi_d  = div_ge ? div_sub : div_sh[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Zero divisor naturally yields quotient all-ones and remainder A.
          ld      = 1'b1;
          ld_res  = sel_q ? hi_q : lo_q;
          ld_ovf  = (b_q == '0);
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (ld) begin
      vld_d = 1'b1;
      res_d = ld_res;
      z_d   = (ld_res == '0);
      n_d   = ld_res[WIDTH-1];
      o_d   = ld_ovf;
      il_d  = ld_ill;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sel_q   <= 1'b0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      o_q     <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      o_q     <= o_d;
      il_q    <= il_d;
    end
  end

  assign out_valid   = vld_q;
  assign Output_Port = res_q;
  assign Zero        = z_q;
  assign Negative    = n_q;
  assign Overflow    = o_q;
  assign Illegal     = il_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc (WIDTH=32) checked every cycle against a queue-based model.
`default_nettype none
module tb_alu_mc;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] Port_A = '0;
  logic [W-1:0] Port_B = '0;
  logic [3:0]   ALUOP = 4'd0;
  logic         in_ready, out_valid, Zero, Negative, Overflow, Illegal;
  logic [W-1:0] Output_Port;

  alu_mc #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Port_A(Port_A), .Port_B(Port_B), .ALUOP(ALUOP),
    .out_valid(out_valid), .out_ready(out_ready), .Output_Port(Output_Port),
    .Zero(Zero), .Negative(Negative), .Overflow(Overflow), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] r;
    logic         z, n, o, il;
    int           due;
  } exp_t;

  exp_t q[$];
  exp_t e_new;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    longint         sa, sb, s;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    e.r = '0; e.o = 1'b0; e.il = 1'b0; e.due = 0;
    case (op)
      4'd0: e.r = a << b[4:0];
      4'd1: e.r = a >> b[4:0];
      4'd2: begin s = sa + sb; e.r = a + b; e.o = (s != longint'($signed(e.r))); end
      4'd3: begin s = sa - sb; e.r = a - b; e.o = (s != longint'($signed(e.r))); end
      4'd4: e.r = a & b;
      4'd5: e.r = a | b;
      4'd6: e.r = a ^ b;
      4'd7: e.r = ~(a | b);
      4'd8: e.r = (sa < sb) ? 1 : 0;
      4'd9: e.r = (a < b) ? 1 : 0;
      4'd10: begin e.r = p[W-1:0]; e.o = (p[2*W-1:W] != 0); end
      4'd11: e.r = p[2*W-1:W];
`ifdef ALU_MC_DIV_EN
      4'd12: begin e.o = (b == 0); e.r = (b == 0) ? '1 : a / b; end
      4'd13: begin e.o = (b == 0); e.r = (b == 0) ? a : a % b; end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == 0);
    e.n = e.r[W-1];
    return e;
  endfunction

  function automatic bit is_multi(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op >= 4'd10) && (op <= 4'd13);
`else
    return (op == 4'd10) || (op == 4'd11);
`endif
  endfunction

  // Per-cycle compare against the transaction queue.
  always @(negedge CLK) begin
    bit ev, busy, eir;
    if (RST) begin
      q.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_result", Output_Port, 0);
      chk("rst_flags", {Zero, Negative, Overflow, Illegal}, 0);
    end else begin
      ev   = (q.size() > 0) && (cyc >= q[0].due);
      busy = (q.size() > 0) && (cyc < q[0].due);
      eir  = !busy && (!ev || out_ready);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, eir);
      if (ev && out_valid) begin
        chk("result", Output_Port, q[0].r);
        chk("zero", Zero, q[0].z);
        chk("negative", Negative, q[0].n);
        chk("overflow", Overflow, q[0].o);
        chk("illegal", Illegal, q[0].il);
      end
      if (ev && out_ready) void'(q.pop_front());
      if (eir && in_valid) begin
        e_new = model(ALUOP, Port_A, Port_B);
        e_new.due = cyc + 1 + (is_multi(ALUOP) ? W + 1 : 0);
        q.push_back(e_new);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    ALUOP = op; Port_A = a; Port_B = b; in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 200) begin n++; @(negedge CLK); end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for op %0d", op);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge CLK); #1; n++; end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge CLK);
    while (!(in_ready && !out_valid) && n < 200) begin n++; @(negedge CLK); end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: block never returned idle");
    end
    @(posedge CLK); #1;
  endtask

  localparam int NV = 14;
  logic [3:0]   v_op [NV] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd5,
                              4'd6, 4'd7, 4'd8, 4'd9, 4'd14, 4'd15};
  logic [W-1:0] v_a  [NV] = '{32'h1, 32'h8000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'd3, 32'hF0F0_1234, 32'h0F00_0000, 32'hAAAA_5555, 32'h0000_FFFF,
                              32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h1};
  logic [W-1:0] v_b  [NV] = '{32'd31, 32'd33, 32'd31, 32'h1, 32'h1,
                              32'd5, 32'hFF00_FF00, 32'h00F0_0000, 32'hFFFF_FFFF, 32'h0000_0F00,
                              32'h1, 32'h1, 32'h9, 32'h2};

  exp_t pm;
  int   lat;

  initial begin
    // Pin the model with hand-computed values.
    pm = model(4'd2, 32'h7FFF_FFFF, 32'h1);
    chk("model_add", {pm.r[31:0]}, 32'h8000_0000);
    chk("model_add_ovf", pm.o, 1);
    pm = model(4'd10, 32'h0001_0000, 32'h0001_0000);
    chk("model_mulu", {pm.z, pm.o}, 2'b11);
    pm = model(4'd11, 32'h0001_0000, 32'h0001_0000);
    chk("model_mulhu", pm.r, 32'h1);
    pm = model(4'd8, 32'hFFFF_FFFF, 32'h1);
    chk("model_slt", pm.r, 32'h1);
    pm = model(4'd3, 32'h8000_0000, 32'h1);
    chk("model_sub_ovf", {pm.r[31:0]}, 32'h7FFF_FFFF);
`ifdef ALU_MC_DIV_EN
    pm = model(4'd12, 32'd100, 32'd7);
    chk("model_divu", pm.r, 32'd14);
    pm = model(4'd13, 32'd100, 32'd7);
    chk("model_remu", pm.r, 32'd2);
    pm = model(4'd12, 32'd5, 32'd0);
    chk("model_div0", pm.r, 32'hFFFF_FFFF);
`else
    pm = model(4'd12, 32'd100, 32'd7);
    chk("model_div_illegal", {pm.r[0], pm.il}, 2'b01);
`endif

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_result", Output_Port, 0);
    @(posedge CLK); #1;

    send(4'd2, 32'h7FFF_FFFF, 32'h1);
    @(negedge CLK);
    chk("add_result", Output_Port, 32'h8000_0000);
    chk("add_flags", {Zero, Negative, Overflow}, 3'b011);
    @(posedge CLK); #1;

    for (int i = 0; i < NV; i++) send(v_op[i], v_a[i], v_b[i]);
    drain();

    send(4'd10, 32'h0001_0000, 32'h0001_0000);
    wait_out(lat);
    chk("mul_latency", lat, 33);
    chk("mulu_result", Output_Port, 32'h0);
    chk("mulu_flags", {Zero, Overflow}, 2'b11);
    drain();

    send(4'd11, 32'h0001_0000, 32'h0001_0000);
    ALUOP = 4'd2; Port_A = 32'h55; Port_B = 32'h66; in_valid = 1'b1;
    repeat (4) @(posedge CLK);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk("mulhu_result", Output_Port, 32'h1);
    drain();

    send(4'd12, 32'd100, 32'd7);
    wait_out(lat);
`ifdef ALU_MC_DIV_EN
    chk("div_latency", lat, 33);
    chk("divu_result", Output_Port, 32'd14);
`else
    chk("div_latency", lat, 0);
    chk("div_illegal", {Output_Port[0], Illegal}, 2'b01);
`endif
    drain();
    send(4'd13, 32'd100, 32'd7);
    drain();
    send(4'd12, 32'd5, 32'd0);
    drain();
    send(4'd13, 32'd5, 32'd0);
    drain();

    out_ready = 1'b0;
    send(4'd3, 32'd10, 32'd3);
    ALUOP = 4'd4; Port_A = 32'h0000_F0F0; Port_B = 32'h0000_FF00; in_valid = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("stall_result", Output_Port, 32'd7);
      chk("stall_flags", {Zero, Negative, Overflow}, 3'b000);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge CLK); #1 out_ready = 1'b1;
    @(negedge CLK);
    chk("stall_release_in_ready", in_ready, 1);
    @(posedge CLK); #1 in_valid = 1'b0;
    @(negedge CLK);
    chk("and_after_stall", Output_Port, 32'h0000_F000);
    chk("and_valid", out_valid, 1);
    @(posedge CLK); #1;
    drain();

    send(4'd10, 32'd3, 32'd5);
    repeat (10) @(posedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    chk("abort_out_valid", out_valid, 0);
    @(posedge CLK); #1 RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("after_abort_valid", out_valid, 0);
      chk("after_abort_in_ready", in_ready, 1);
    end
    @(posedge CLK); #1;
    send(4'd8, 32'hFFFF_FFFF, 32'h1);
    @(negedge CLK);
    chk("slt_result", Output_Port, 32'h1);
    @(posedge CLK); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
